logic_unit_arbiter_32bit: RTL and testbench

Round-robin arbiter and sequencer that shares a single 32-bit bitwise logic unit (NOT/AND/OR/XOR) between two requesters. It accepts one operation at a time over a valid/ready handshake and computes the result into a register. It returns the result with the requester ID over a valid/ready response channel. It sits in front of the 32-bit gate datapath, so the gate logic is instantiated once rather than per client.

---
 rtl/logic_unit_arbiter_32bit.sv | 197 +++++++++++++++++++
 tb/tb_logic_unit_arbiter_32bit.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/logic_unit_arbiter_32bit.sv
// ----------------------------------------------------------------------------
// logic_unit_arbiter_32bit
//
// Shares one WIDTH-bit bitwise logic unit (NOT/AND/OR/XOR) between two
// requesters. A round-robin pointer picks the winner when both requesters
// are valid. The winning operation is latched, evaluated in EXEC, and
// returned on a response channel that carries the requester ID.
//
// Handshakes: a transfer happens on a channel in the cycle where both valid
// and ready are high at the rising clock edge. A producer holds valid and
// payload stable until it sees ready. Ready never depends on the consumer's
// own valid in a way that creates a loop. req ready depends only on state,
// both valids and prio. resp_ready never feeds back into req ready.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   reqN_valid/ready/op/a/b     request channel of requester N (N = 0, 1)
//   resp_valid/ready/data/id    response channel (result + requester ID)
//   busy                        registered, high in EXEC and RESP
//   dbg_state                   current FSM state (0 IDLE, 1 EXEC, 2 RESP)
//   grant_cnt0/1                saturating accepted-handshake counters,
//                               present only when LOGIC_ARB_CNT_EN is defined
//
// Build option: define LOGIC_ARB_CNT_EN to add the grant counters.
// ----------------------------------------------------------------------------
module logic_unit_arbiter_32bit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_data,
    output logic             resp_id,
    output logic             busy,
    output logic [1:0]       dbg_state
`ifdef LOGIC_ARB_CNT_EN
    ,
    output logic [15:0]      grant_cnt0,
    output logic [15:0]      grant_cnt1
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             prio_q, prio_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             id_q, id_d;
    logic [WIDTH-1:0] resp_data_q, resp_data_d;
    logic             resp_id_q, resp_id_d;
    logic             busy_q, busy_d;

    logic             grant_id;
    logic             handshake;
    logic [WIDTH-1:0] alu_result;

    // Lone requester wins outright; on contention prio names the winner.
    assign grant_id = (req0_valid && req1_valid) ? prio_q : req1_valid;

    // The single shared logic unit, fed only from the latched operands.
    always_comb begin
        alu_result = '0;
        case (op_q)
            2'b00:   alu_result = ~a_q;
            2'b01:   alu_result = a_q & b_q;
            2'b10:   alu_result = a_q | b_q;
            default: alu_result = a_q ^ b_q;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        prio_d      = prio_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        id_d        = id_q;
        resp_data_d = resp_data_q;
        resp_id_d   = resp_id_q;
        busy_d      = busy_q;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        handshake   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // rst_n gating keeps both readies low while reset is held,
                // even if a requester is still presenting valid.
                if ((req0_valid || req1_valid) && rst_n) begin
                    req0_ready = ~grant_id;
                    req1_ready = grant_id;
                    handshake  = 1'b1;
                    op_d       = grant_id ? req1_op : req0_op;
                    a_d        = grant_id ? req1_a  : req0_a;
                    b_d        = grant_id ? req1_b  : req0_b;
                    id_d       = grant_id;
                    prio_d     = ~grant_id;
                    busy_d     = 1'b1;
                    state_d    = ST_EXEC;
                end
            end
            ST_EXEC: begin
                resp_data_d = alu_result;
                resp_id_d   = id_q;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (resp_ready) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            prio_q      <= 1'b0;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            id_q        <= 1'b0;
            resp_data_q <= '0;
            resp_id_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            prio_q      <= prio_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            id_q        <= id_d;
            resp_data_q <= resp_data_d;
            resp_id_q   <= resp_id_d;
            busy_q      <= busy_d;
        end
    end

    assign resp_valid = (state_q == ST_RESP);
    assign resp_data  = resp_data_q;
    assign resp_id    = resp_id_q;
    assign busy       = busy_q;
    assign dbg_state  = state_q;

`ifdef LOGIC_ARB_CNT_EN
    logic [15:0] grant_cnt0_q, grant_cnt0_d;
    logic [15:0] grant_cnt1_q, grant_cnt1_d;

    // Counters stick at all-ones instead of wrapping.
    always_comb begin
        grant_cnt0_d = grant_cnt0_q;
        grant_cnt1_d = grant_cnt1_q;
        if (handshake && !grant_id && (grant_cnt0_q != 16'hFFFF)) begin
            grant_cnt0_d = grant_cnt0_q + 16'd1;
        end
        if (handshake && grant_id && (grant_cnt1_q != 16'hFFFF)) begin
            grant_cnt1_d = grant_cnt1_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt0_q <= 16'd0;
            grant_cnt1_q <= 16'd0;
        end else begin
            grant_cnt0_q <= grant_cnt0_d;
            grant_cnt1_q <= grant_cnt1_d;
        end
    end

    assign grant_cnt0 = grant_cnt0_q;
    assign grant_cnt1 = grant_cnt1_q;
`endif

endmodule

// File: tb/tb_logic_unit_arbiter_32bit.sv
// ----------------------------------------------------------------------------
// tb_logic_unit_arbiter_32bit
//
// Directed bench for logic_unit_arbiter_32bit: reset values, all four ops,
// round-robin contention, response backpressure, back-to-back throughput
// and (with LOGIC_ARB_CNT_EN) the saturating grant counters.
// Outputs are sampled 1 time unit after the rising edge.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_logic_unit_arbiter_32bit;

  localparam int W = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic         req0_ready, req1_ready;
  logic [1:0]   req0_op = '0, req1_op = '0;
  logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic         resp_valid, resp_id, busy;
  logic         resp_ready = 1'b1;
  logic [W-1:0] resp_data;
  logic [1:0]   dbg_state;
`ifdef LOGIC_ARB_CNT_EN
  logic [15:0]  grant_cnt0, grant_cnt1;
`endif

  logic_unit_arbiter_32bit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_id(resp_id),
    .busy(busy), .dbg_state(dbg_state)
`ifdef LOGIC_ARB_CNT_EN
    , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- check helper ----------------
  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    resp_ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  // One isolated operation from requester id, with resp_ready held high.
  task automatic run_op(input logic id, input logic [1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp, input string tag);
    if (id) begin
      req1_op = op; req1_a = a; req1_b = b; req1_valid = 1'b1; req0_valid = 1'b0;
    end else begin
      req0_op = op; req0_a = a; req0_b = b; req0_valid = 1'b1; req1_valid = 1'b0;
    end
    resp_ready = 1'b1;
    #1;
    chk({tag, "_state_idle"}, W'(dbg_state), W'(2'd0));
    chk({tag, "_ready0"}, W'(req0_ready), W'(!id));
    chk({tag, "_ready1"}, W'(req1_ready), W'(id));
    tick();                             // handshake edge T
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk({tag, "_exec_no_valid"}, W'(resp_valid), W'(1'b0));
    chk({tag, "_exec_busy"}, W'(busy), W'(1'b1));
    tick();                             // edge T+1 -> RESP
    chk({tag, "_resp_valid"}, W'(resp_valid), W'(1'b1));
    chk({tag, "_data"}, resp_data, exp);
    chk({tag, "_id"}, W'(resp_id), W'(id));
    tick();                             // edge T+2 consumes response
    chk({tag, "_done_valid"}, W'(resp_valid), W'(1'b0));
    chk({tag, "_done_busy"}, W'(busy), W'(1'b0));
  endtask

  // ---------------- directed sequence ----------------
  initial begin : stim
    logic seen;
    logic eid;

    // reset values straight out of an asserted reset
    #1 rst_n = 1'b0;
    #1;
    chk("rst_resp_valid", W'(resp_valid), W'(1'b0));
    chk("rst_resp_data", resp_data, 32'h0);
    chk("rst_busy", W'(busy), W'(1'b0));
    do_reset();

    // single requester, all four ops
    run_op(1'b0, 2'b00, 32'h1234_5678, 32'h0000_FFFF, 32'hEDCB_A987, "not");
    run_op(1'b0, 2'b01, 32'h1234_5678, 32'h0000_FFFF, 32'h0000_5678, "and");
    run_op(1'b0, 2'b10, 32'h1234_5678, 32'h0000_FFFF, 32'h1234_FFFF, "or");
    run_op(1'b0, 2'b11, 32'h1234_5678, 32'h0000_FFFF, 32'h1234_A987, "xor");
    run_op(1'b1, 2'b01, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, "and_req1");

    // reset in the middle of EXEC drops the operation
    req0_op = 2'b01; req0_a = 32'hFFFF_FFFF; req0_b = 32'hAAAA_5555; req0_valid = 1'b1;
    tick();                             // handshake, now in EXEC
    chk("rstx_in_exec", W'(dbg_state), W'(2'd1));
    #2 rst_n = 1'b0;
    #1;
    chk("rstx_resp_valid", W'(resp_valid), W'(1'b0));
    chk("rstx_resp_data", resp_data, 32'h0);
    chk("rstx_resp_id", W'(resp_id), W'(1'b0));
    chk("rstx_busy", W'(busy), W'(1'b0));
    chk("rstx_ready0", W'(req0_ready), W'(1'b0));
    chk("rstx_ready1", W'(req1_ready), W'(1'b0));
    req0_valid = 1'b0;
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      tick();
      if (resp_valid) seen = 1'b1;
    end
    chk("rstx_no_response", W'(seen), W'(1'b0));

    // simultaneous requests from reset: 0,1,0,1 alternation
    do_reset();
    req0_op = 2'b00; req0_a = 32'hFFFF_FFFF; req0_b = 32'h0;
    req1_op = 2'b00; req1_a = 32'h0000_0000; req1_b = 32'h0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      eid = k[0];
      chk($sformatf("rr%0d_idle", k), W'(dbg_state), W'(2'd0));
      chk($sformatf("rr%0d_busy_lo", k), W'(busy), W'(1'b0));
      chk($sformatf("rr%0d_ready0", k), W'(req0_ready), W'(!eid));
      chk($sformatf("rr%0d_ready1", k), W'(req1_ready), W'(eid));
      tick();
      chk($sformatf("rr%0d_busy_exec", k), W'(busy), W'(1'b1));
      tick();
      chk($sformatf("rr%0d_valid", k), W'(resp_valid), W'(1'b1));
      chk($sformatf("rr%0d_id", k), W'(resp_id), W'(eid));
      chk($sformatf("rr%0d_data", k), resp_data, eid ? 32'hFFFF_FFFF : 32'h0000_0000);
      chk($sformatf("rr%0d_busy_resp", k), W'(busy), W'(1'b1));
      tick();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    // back-to-back from req1 alone: handshake every 3 cycles
    req1_op = 2'b10; req1_a = 32'h0F0F_0000; req1_b = 32'h0000_F0F0;
    req1_valid = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("b2b%0d_ready1", k), W'(req1_ready), W'(1'b1));
      chk($sformatf("b2b%0d_busy0", k), W'(busy), W'(1'b0));
      tick();
      chk($sformatf("b2b%0d_ready1_exec", k), W'(req1_ready), W'(1'b0));
      chk($sformatf("b2b%0d_busy1", k), W'(busy), W'(1'b1));
      tick();
      chk($sformatf("b2b%0d_data", k), resp_data, 32'h0F0F_F0F0);
      chk($sformatf("b2b%0d_busy2", k), W'(busy), W'(1'b1));
      tick();
    end
    req1_valid = 1'b0;

    // backpressure: 10 stalled cycles in RESP
    tick();
    resp_ready = 1'b0;
    req0_op = 2'b11; req0_a = 32'hFF00_FF00; req0_b = 32'h0F0F_0F0F; req0_valid = 1'b1;
    tick();                             // handshake
    req0_valid = 1'b0;
    req1_valid = 1'b1;                  // a waiting requester must not be granted
    tick();
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("bp%0d_valid", k), W'(resp_valid), W'(1'b1));
      chk($sformatf("bp%0d_data", k), resp_data, 32'hF00F_F00F);
      chk($sformatf("bp%0d_id", k), W'(resp_id), W'(1'b0));
      chk($sformatf("bp%0d_ready0", k), W'(req0_ready), W'(1'b0));
      chk($sformatf("bp%0d_ready1", k), W'(req1_ready), W'(1'b0));
      tick();
    end
    req1_valid = 1'b0;
    resp_ready = 1'b1;
    tick();
    chk("bp_back_idle", W'(dbg_state), W'(2'd0));
    chk("bp_valid_low", W'(resp_valid), W'(1'b0));

`ifdef LOGIC_ARB_CNT_EN
    // grant counters
    do_reset();
    chk("cnt0_reset", W'(grant_cnt0), W'(16'd0));
    for (int k = 0; k < 5; k++) run_op(1'b0, 2'b01, 32'hFFFF_0000, 32'h00FF_FF00, 32'h00FF_0000, "cnt_r0");
    for (int k = 0; k < 3; k++) run_op(1'b1, 2'b10, 32'h0000_0001, 32'h8000_0000, 32'h8000_0001, "cnt_r1");
    chk("cnt0_five", W'(grant_cnt0), W'(16'd5));
    chk("cnt1_three", W'(grant_cnt1), W'(16'd3));
    @(negedge clk);
    force dut.grant_cnt0_q = 16'hFFFF;
    #1 release dut.grant_cnt0_q;
    tick();
    run_op(1'b0, 2'b00, 32'h0, 32'h0, 32'hFFFF_FFFF, "cnt_sat");
    chk("cnt0_saturated", W'(grant_cnt0), W'(16'hFFFF));
    chk("cnt1_unchanged", W'(grant_cnt1), W'(16'd3));
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
